// File: rtl/binarytoascii.sv
// rtl/binarytoascii.sv - serialises a byte as eight ASCII '0'/'1' characters, MSB first, with optional CR/LF
module binarytoascii #(
  parameter bit APPEND_EOL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] tx_data,
  output logic       tx_dv,
  input  logic       tx_done,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BIT,
    WAIT_CR,
    WAIT_LF
  } state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  state_t     state_q, state_d;
  // Only bits 6:0 of the byte are kept; bit 7 is consumed at acceptance.
  logic [6:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_dv_q, tx_dv_d;
  logic       busy_q, busy_d;
  logic       in_ready_q, in_ready_d;

  // Next-state logic: each tx_done advances to the next character; tx_dv is a one-cycle strobe.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    tx_dv_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d   = in_byte[6:0];
          tx_data_d = ASCII_ZERO | {7'd0, in_byte[7]};
          tx_dv_d   = 1'b1;
          cnt_d     = 3'd7;
          state_d   = WAIT_BIT;
        end
      end
      WAIT_BIT: begin
        if (tx_done) begin
          if (cnt_q != 3'd0) begin
            cnt_d     = cnt_q - 3'd1;
            shift_d   = {shift_q[5:0], 1'b0};
            tx_data_d = ASCII_ZERO | {7'd0, shift_q[6]};
            tx_dv_d   = 1'b1;
          end else if (APPEND_EOL) begin
            tx_data_d = ASCII_CR;
            tx_dv_d   = 1'b1;
            state_d   = WAIT_CR;
          end else begin
            state_d   = IDLE;
          end
        end
      end
      WAIT_CR: begin
        if (tx_done) begin
          tx_data_d = ASCII_LF;
          tx_dv_d   = 1'b1;
          state_d   = WAIT_LF;
        end
      end
      WAIT_LF: begin
        if (tx_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d     = (state_d != IDLE);
    in_ready_d = (state_d == IDLE);
  end

  // State and registered outputs; reset cuts off any character in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      shift_q    <= 7'd0;
      cnt_q      <= 3'd0;
      tx_data_q  <= 8'h00;
      tx_dv_q    <= 1'b0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_dv_q    <= tx_dv_d;
      busy_q     <= busy_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_dv    = tx_dv_q;
  assign busy     = busy_q;
  assign in_ready = in_ready_q;

endmodule
